// File: rtl/panel_pkg.sv
// Shared types for the switch-driven debug panel: commit modes, FSM states, bank reset pattern.
// Pure declarations; no latency or flow control.
package panel_pkg;

  typedef enum logic [1:0] {
    MODE_VIEW  = 2'b00,
    MODE_LOAD  = 2'b01,
    MODE_CLEAR = 2'b10,
    MODE_HOLD  = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  // Distinct, easy-to-recognise power-on contents: entry i reads back as i*17.
  function automatic logic [31:0] reset_pattern(input int idx);
    return 32'(idx * 17);
  endfunction

endpackage

// File: rtl/panel_ctrl_tick_counter.sv
// Prescaled free-running counter with a freeze input; one increment every PRESCALE cycles.
// Output is registered; hold_i freezes prescaler and counter in place (no backpressure otherwise).
module tick_counter #(
  parameter int PRESCALE = 1,
  parameter int CNT_BITS = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                hold_i,
  output logic [CNT_BITS-1:0] cnt_o
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0]     pre_q, pre_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;

  always_comb begin
    pre_d = pre_q;
    cnt_d = cnt_q;
    if (!hold_i) begin
      if (pre_q == PS_LAST) begin
        pre_d = '0;
        cnt_d = cnt_q + 1'b1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/panel_ctrl.sv
// Debug panel: switch-editable register bank, pointer, clear sweeper and prescaled counter driving LED/SEG/LCD.
// Commits act on the edge they are seen and show the cycle after; commits during a clear sweep are dropped.
module panel_ctrl
  import panel_pkg::*;
#(
  parameter int NBITS    = 8,
  parameter int NREGS    = 32,
  parameter int CNT_BITS = 4,
  parameter int PRESCALE = 1
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic [NBITS-1:0] SWI,
  output logic [NBITS-1:0] LED,
  output logic [NBITS-1:0] SEG,
  output logic [NBITS-1:0] lcd_registrador [0:NREGS-1],
  output logic [NBITS-1:0] lcd_pc
);

  localparam int PTR_W  = $clog2(NREGS);
  localparam int DATA_W = NBITS - 3;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NREGS - 1);

  state_e             state_q, state_d;
  logic               swi_q;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   idx_q, idx_d;
  logic               hold_q, hold_d;
  logic [NBITS-1:0]   bank_q [0:NREGS-1];

  logic               bank_we;
  logic [PTR_W-1:0]   bank_wa;
  logic [NBITS-1:0]   bank_wd;

  logic               commit;
  mode_e              mode;
  logic [NBITS-1:0]   data;
  logic               busy;
  logic [CNT_BITS-1:0] cnt;

  // Only the commit switch needs history; resetting it high masks a switch already up at release.
  assign commit = SWI[NBITS-1] & ~swi_q;
  assign mode   = mode_e'(SWI[NBITS-2 -: 2]);
  assign data   = {3'b000, SWI[DATA_W-1:0]};

  tick_counter #(
    .PRESCALE (PRESCALE),
    .CNT_BITS (CNT_BITS)
  ) u_tick (
    .clk_i  (clk_2),
    .rst_i  (reset),
    .hold_i (hold_q),
    .cnt_o  (cnt)
  );

  always_ff @(posedge clk_2) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (commit && mode == MODE_CLEAR) state_d = ST_CLEAR;
      ST_CLEAR: if (idx_q == LAST_IDX)            state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_CLEAR);
    LED  = '0;
    LED[NBITS-1 -: CNT_BITS] = cnt;
    LED[3:2] = SWI[NBITS-2 -: 2];
    LED[1]   = hold_q;
    LED[0]   = busy;
  end

  always_comb begin
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    bank_we = 1'b0;
    bank_wa = ptr_q;
    bank_wd = data;
    if (state_q == ST_CLEAR) begin
      bank_we = 1'b1;
      bank_wa = idx_q;
      bank_wd = '0;
      idx_d   = idx_q + 1'b1;
      if (idx_q == LAST_IDX) ptr_d = '0;
    end else if (commit) begin
      case (mode)
        MODE_VIEW:  ptr_d = ptr_q + 1'b1;
        MODE_LOAD: begin
          bank_we = 1'b1;
          ptr_d   = ptr_q + 1'b1;
        end
        MODE_CLEAR: idx_d  = '0;
        MODE_HOLD:  hold_d = ~hold_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      swi_q  <= 1'b1;
      ptr_q  <= '0;
      idx_q  <= '0;
      hold_q <= 1'b0;
    end else begin
      swi_q  <= SWI[NBITS-1];
      ptr_q  <= ptr_d;
      idx_q  <= idx_d;
      hold_q <= hold_d;
    end
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) bank_q[i] <= NBITS'(reset_pattern(i));
    end else if (bank_we) begin
      bank_q[bank_wa] <= bank_wd;
    end
  end

  assign SEG             = bank_q[ptr_q];
  assign lcd_registrador = bank_q;

  always_comb begin
    lcd_pc = '0;
    lcd_pc[PTR_W-1:0] = ptr_q;
  end

endmodule

// File: tb/tb_panel_ctrl.sv
// Directed bench for panel_ctrl: a PRESCALE=1 and a PRESCALE=4 instance share clock, reset and switches.
module tb_panel_ctrl;

  logic       clk_2 = 1'b0;
  logic       reset;
  logic [7:0] swi;

  logic [7:0] led1, seg1, pc1;
  logic [7:0] reg1 [0:31];
  logic [7:0] led4, seg4, pc4;
  logic [7:0] reg4 [0:31];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] swi;
    logic [7:0] pc;
    logic [7:0] seg;
    logic [1:0] mode;
  } vec_t;

  vec_t vecs [11];

  panel_ctrl #(.NBITS(8), .NREGS(32), .CNT_BITS(4), .PRESCALE(1)) dut (
    .clk_2 (clk_2), .reset (reset), .SWI (swi),
    .LED (led1), .SEG (seg1), .lcd_registrador (reg1), .lcd_pc (pc1)
  );

  panel_ctrl #(.NBITS(8), .NREGS(32), .CNT_BITS(4), .PRESCALE(4)) dut4 (
    .clk_2 (clk_2), .reset (reset), .SWI (swi),
    .LED (led4), .SEG (seg4), .lcd_registrador (reg4), .lcd_pc (pc4)
  );

  always #5 clk_2 = ~clk_2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  initial begin
    int n;
    logic [7:0] e;

    vecs[0]  = '{swi: 8'hA5, pc: 8'd1, seg: 8'h11, mode: 2'b01};
    vecs[1]  = '{swi: 8'hA5, pc: 8'd1, seg: 8'h11, mode: 2'b01};
    vecs[2]  = '{swi: 8'h00, pc: 8'd1, seg: 8'h11, mode: 2'b00};
    vecs[3]  = '{swi: 8'hA3, pc: 8'd2, seg: 8'h22, mode: 2'b01};
    vecs[4]  = '{swi: 8'h20, pc: 8'd2, seg: 8'h22, mode: 2'b01};
    vecs[5]  = '{swi: 8'h9F, pc: 8'd3, seg: 8'h33, mode: 2'b00};
    vecs[6]  = '{swi: 8'h1F, pc: 8'd3, seg: 8'h33, mode: 2'b00};
    vecs[7]  = '{swi: 8'hBF, pc: 8'd4, seg: 8'h44, mode: 2'b01};
    vecs[8]  = '{swi: 8'h3F, pc: 8'd4, seg: 8'h44, mode: 2'b01};
    vecs[9]  = '{swi: 8'h80, pc: 8'd5, seg: 8'h55, mode: 2'b00};
    vecs[10] = '{swi: 8'h00, pc: 8'd5, seg: 8'h55, mode: 2'b00};

    // Reset with the commit switch already up: release must not commit.
    reset = 1'b1;
    swi   = 8'h80;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_led", led1, 8'h00);
    chk("rst_seg", seg1, 8'h00);
    chk("rst_pc", pc1, 8'h00);
    chk("rst_bank15", reg1[15], 8'hFF);
    chk("rst_pc4", pc4, 8'h00);
    tick();
    chk("rst_cnt1", led1[7:4], 4'd1);
    chk("rst_nocommit", pc1, 8'h00);
    tick();
    chk("rst_cnt2", led1[7:4], 4'd2);

    swi = 8'h00;
    tick();
    for (int i = 0; i < 33; i++) begin
      swi = 8'h80; tick();
      swi = 8'h00; tick();
    end
    chk("view_wrap_pc", pc1, 8'd1);
    chk("view_wrap_seg", seg1, 8'h11);
    for (int i = 0; i < 31; i++) begin
      swi = 8'h80; tick();
      swi = 8'h00; tick();
    end
    chk("view_back_to0", pc1, 8'd0);

    for (int i = 0; i < 11; i++) begin
      swi = vecs[i].swi;
      tick();
      chk($sformatf("vec%0d_pc", i), pc1, vecs[i].pc);
      chk($sformatf("vec%0d_seg", i), seg1, vecs[i].seg);
      chk($sformatf("vec%0d_mode", i), led1[3:2], vecs[i].mode);
    end
    chk("load_bank0", reg1[0], 8'h05);
    chk("load_bank1", reg1[1], 8'h03);
    chk("view_bank2", reg1[2], 8'h22);
    chk("load_bank3", reg1[3], 8'h1F);

    // Held commit switch writes exactly once.
    swi = 8'hA5;
    tick();
    chk("held_first_pc", pc1, 8'd6);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("held_pc", pc1, 8'd6);
      chk("held_bank6", reg1[6], 8'h66);
    end
    chk("held_bank5", reg1[5], 8'h05);

    swi = 8'h00; tick();
    swi = 8'h80; tick();
    swi = 8'h00; tick();
    chk("clr_pre_pc", pc1, 8'd7);
    swi = 8'hC0;
    tick();
    for (int j = 1; j <= 32; j++) begin
      if (j == 5)  swi = 8'h00;
      if (j == 6)  swi = 8'hC0;
      if (j == 9)  swi = 8'h00;
      if (j == 10) swi = 8'hA5;
      tick();
      if (j < 32) chk($sformatf("clr_busy_%0d", j), led1[0], 1'b1);
    end
    chk("clr_done_busy", led1[0], 1'b0);
    chk("clr_done_pc", pc1, 8'd0);
    for (int i = 0; i < 32; i++) chk($sformatf("clr_bank%0d", i), reg1[i], 8'h00);
    tick();
    chk("clr_nodefer_pc", pc1, 8'd0);
    chk("clr_nodefer_bank0", reg1[0], 8'h00);
    chk("clr_nodefer_busy", led1[0], 1'b0);

    // Freeze the PRESCALE=4 counter right after it steps to 3.
    swi = 8'h60;
    n = 0;
    while (led4[7:4] == 4'd3 && n < 100) begin tick(); n++; end
    while (led4[7:4] != 4'd3 && n < 200) begin tick(); n++; end
    chk("hold_wait_in_budget", (n < 200), 1'b1);
    swi = 8'hE0;
    tick();
    chk("hold_on_cnt", led4[7:4], 4'd3);
    chk("hold_on_flag", led4[1], 1'b1);
    swi = 8'h60;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold_frozen_cnt", led4[7:4], 4'd3);
      chk("hold_frozen_flag", led4[1], 1'b1);
    end
    chk("hold_flag_dut1", led1[1], 1'b1);
    swi = 8'hE0;
    tick();
    chk("hold_off_flag", led4[1], 1'b0);
    chk("hold_off_cnt", led4[7:4], 4'd3);
    for (int j = 1; j <= 8; j++) begin
      tick();
      e = 8'd3 + ((j >= 3) ? 8'd1 : 8'd0) + ((j >= 7) ? 8'd1 : 8'd0);
      chk($sformatf("resume_cnt_%0d", j), led4[7:4], e[3:0]);
    end

    swi = 8'h40; tick();
    swi = 8'hC0; tick();
    for (int i = 0; i < 5; i++) tick();
    chk("midclr_busy", led1[0], 1'b1);
    reset = 1'b1;
    tick();
    for (int i = 0; i < 32; i++) begin
      e = 8'(i * 17);
      chk($sformatf("midclr_rst_bank%0d", i), reg1[i], e);
    end
    chk("midclr_rst_led", led1, 8'h08);
    chk("midclr_rst_led4", led4, 8'h08);
    chk("midclr_rst_pc", pc1, 8'd0);
    chk("midclr_rst_seg4", seg4, 8'h00);
    chk("midclr_rst_bank4_15", reg4[15], 8'hFF);
    reset = 1'b0;
    tick();
    chk("post_rst_busy", led1[0], 1'b0);
    chk("post_rst_cnt", led1[7:4], 4'd1);
    chk("post_rst_pc", pc1, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
